adder_share_arb: RTL and testbench
==================================

// Module: adder_share_arb
// PURPOSE
//   Shares one pipelined 8-bit adder (ports din_1, din_2, cin -> dout, cout) among N_REQ requesters.
//   - Round-robin arbitration, one operand set issued per cycle.
//   - Each operand set is tagged with its requester id; the tag travels alongside the adder pipeline.
//   - Each result is returned to its originating requester.
//   - Sits between the client blocks and the adder instance; the adder itself is unchanged.
// PARAMETERS
//   N_REQ     4   number of requesters (2..8)
//   DATA_W    8   operand/sum width; must match the adder
//   PIPE_LAT  2   adder latency: cycles from operands registered on add_din_* to valid add_dout/add_cout
// PORTS
//   clk        in   1               system clock, rising edge
//   rst_n      in   1               async active-low reset
//   arb_en     in   1               1 = grants allowed; 0 = no new grants, in-flight results drain
//   req_valid  in   N_REQ           per-requester operand valid
//   req_ready  out  N_REQ           per-requester accept (one-hot or zero)
//   req_a      in   N_REQ*DATA_W    operand A, requester i at [i*DATA_W +: DATA_W]
//   req_b      in   N_REQ*DATA_W    operand B, same packing
//   req_cin    in   N_REQ           carry-in per requester
//   add_din_1  out  DATA_W          to adder din_1 (registered)
//   add_din_2  out  DATA_W          to adder din_2 (registered)
//   add_cin    out  1               to adder cin (registered)
//   add_dout   in   DATA_W          from adder dout
//   add_cout   in   1               from adder cout
//   rsp_valid  out  N_REQ           one-hot result strobe, one cycle, no backpressure
//   rsp_sum    out  DATA_W          result sum, shared by all requesters
//   rsp_cout   out  1               result carry-out
//   inflight   out  $clog2(PIPE_LAT+2)  accepted-but-not-returned count
// BEHAVIOUR
//   - Reset: all outputs 0; tag pipe cleared; rr pointer = N_REQ-1, so requester 0 has first priority.
//   - Arbitration (combinational):
//     - Winner = first i with req_valid[i], scanning from (ptr+1) mod N_REQ upward with wrap.
//     - req_ready[winner] = arb_en; all other req_ready bits are 0.
//     - req_ready depends on req_valid; requesters must not make req_valid depend on req_ready.
//   - Transfer = req_valid[i] & req_ready[i] at a rising edge. On a transfer:
//     - add_din_1/add_din_2/add_cin <= winner's operands;
//     - tag stage 0 <= {1, id};
//     - ptr <= id.
//   - No transfer: add_* hold their previous value; tag stage 0 valid <= 0; ptr holds.
//   - Fairness: a continuously valid requester waits at most N_REQ-1 transfers.
//   - Tag pipe depth PIPE_LAT. Its head aligns with add_dout/add_cout.
//     - Next edge: rsp_valid <= onehot(head id) & {N_REQ{head valid}}; rsp_sum <= add_dout; rsp_cout <= add_cout.
//     - rsp_sum/rsp_cout update only when head valid; otherwise they hold.
//   - Latency: transfer at edge E -> rsp_valid high for exactly the cycle after edge E+PIPE_LAT+1.
//     - Throughput 1/cycle; results return in acceptance order.
//   - Width rules:
//     - Sum and carry are taken verbatim from the adder; no re-computation.
//     - {rsp_cout, rsp_sum} = a + b + cin, modulo 2^(DATA_W+1).
//   - inflight: +1 on transfer, -1 on rsp_valid != 0, unchanged when both occur. Never exceeds PIPE_LAT+1.
//   - arb_en falling mid-stream: no new grants; already-accepted ops complete normally.
//   - Reset mid-operation: in-flight ops are discarded.
//     - No rsp_valid for stale adder outputs after release.
//     - inflight = 0; arbitration restarts at requester 0.
// STRUCTURE
//   - Package adder_arb_pkg:
//     - localparams N_REQ_MAX=8, DATA_W=8;
//     - typedef logic [$clog2(N_REQ_MAX)-1:0] req_id_t;
//     - typedef struct packed {logic vld; req_id_t id;} tag_t.
//   - Sub-module rr_arbiter:
//     - parameter N;
//     - in: req[N], en, advance;
//     - out: grant[N] one-hot, grant_id;
//     - owns the pointer.
//   - Top level: operand mux, issue registers, tag shift register, response registers, inflight counter.
// TESTING
//   1. Req 0 only, a=8'd5, b=8'd10, cin=0, PIPE_LAT=2 -> rsp_valid=4'b0001 three cycles after accept; sum=15, cout=0.
//   2. All 4 valid every cycle, distinct operands -> grants 0,1,2,3,0,...; each rsp_valid one-hot matches issuing id.
//   3. Req 1: a=8'hFF, b=8'h01, cin=1 -> rsp_sum=8'h01, rsp_cout=1.
//   4. Req 2 streams 50 ops, a=0..49, b=10..59, cin=0 -> sums 10,12,...,108 in order, one per cycle.
//   5. arb_en=0 with 3 in flight and reqs pending -> req_ready=0; 3 responses arrive; inflight reaches 0.
//   6. rst_n pulsed low with 3 in flight -> no rsp_valid after release; inflight=0; next grant goes to req 0.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// Shared types for the adder-sharing arbiter: requester id and the tag that
// travels alongside the adder pipeline.
package adder_arb_pkg;

  localparam int N_REQ_MAX = 8;
  localparam int DATA_W    = 8;

  typedef logic [$clog2(N_REQ_MAX)-1:0] req_id_t;

  typedef struct packed {
    logic    vld;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans upward from the requester after the last winner,
// wrapping, and moves its pointer to the winner whenever a grant is taken.
module rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         en,
  input  logic         advance,
  output logic [N-1:0] grant,
  output req_id_t      grant_id
);

  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  req_id_t      ptr_q;
  req_id_t      ptr_d;
  logic [N-1:0] hi_mask_s;
  logic [N-1:0] pick_s;

  // Requesters above the pointer take precedence; fall back to the full set on wrap.
  always_comb begin
    hi_mask_s = '0;
    for (int i = 0; i < N; i++) begin
      hi_mask_s[i] = (i > int'(ptr_q));
    end
    pick_s = (|(req & hi_mask_s)) ? (req & hi_mask_s) : req;
  end

  // Lowest set bit of the chosen set is the winner.
  always_comb begin
    grant_id = '0;
    for (int i = N - 1; i >= 0; i--) begin
      grant_id = pick_s[i] ? req_id_t'(i) : grant_id;
    end
    grant = (en && (|req)) ? (ONE_HOT0 << grant_id) : '0;
    ptr_d = advance ? grant_id : ptr_q;
  end

  // Pointer register; reset value makes requester 0 first in line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= req_id_t'(N - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/adder_share_arb.sv
// Shares one pipelined adder among N_REQ requesters: round-robin issue, a tag
// pipe that tracks the owner of each in-flight sum, and per-requester return.
module adder_share_arb #(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 8,
  parameter int PIPE_LAT = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            arb_en,
  input  logic [N_REQ-1:0]                req_valid,
  output logic [N_REQ-1:0]                req_ready,
  input  logic [N_REQ*DATA_W-1:0]         req_a,
  input  logic [N_REQ*DATA_W-1:0]         req_b,
  input  logic [N_REQ-1:0]                req_cin,
  output logic [DATA_W-1:0]               add_din_1,
  output logic [DATA_W-1:0]               add_din_2,
  output logic                            add_cin,
  input  logic [DATA_W-1:0]               add_dout,
  input  logic                            add_cout,
  output logic [N_REQ-1:0]                rsp_valid,
  output logic [DATA_W-1:0]               rsp_sum,
  output logic                            rsp_cout,
  output logic [$clog2(PIPE_LAT+2)-1:0]   inflight
);

  localparam int                 CNT_W    = $clog2(PIPE_LAT + 2);
  localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [N_REQ-1:0]   ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  logic [N_REQ-1:0]          grant_s;
  adder_arb_pkg::req_id_t    grant_id_s;
  logic                      xfer_s;
  logic [DATA_W-1:0]         sel_a_s;
  logic [DATA_W-1:0]         sel_b_s;
  logic                      sel_cin_s;

  logic [DATA_W-1:0]         din1_q, din1_d;
  logic [DATA_W-1:0]         din2_q, din2_d;
  logic                      cin_q,  cin_d;

  // Stage 0 sits beside add_din_*; stage PIPE_LAT lines up with add_dout.
  adder_arb_pkg::tag_t       tag_q [0:PIPE_LAT];
  adder_arb_pkg::tag_t       tag_d [0:PIPE_LAT];
  adder_arb_pkg::tag_t       head_s;

  logic [N_REQ-1:0]          rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]         rsp_sum_q,   rsp_sum_d;
  logic                      rsp_cout_q,  rsp_cout_d;
  logic [CNT_W-1:0]          inflight_q,  inflight_d;

  rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req_valid),
    .en       (arb_en),
    .advance  (xfer_s),
    .grant    (grant_s),
    .grant_id (grant_id_s)
  );

  assign req_ready = grant_s;
  assign xfer_s    = |(req_valid & grant_s);
  assign head_s    = tag_q[PIPE_LAT];

  // One-hot AND-OR operand mux driven by the grant vector.
  always_comb begin
    sel_a_s   = '0;
    sel_b_s   = '0;
    sel_cin_s = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_a_s   = sel_a_s | (req_a[i*DATA_W +: DATA_W] & {DATA_W{grant_s[i]}});
      sel_b_s   = sel_b_s | (req_b[i*DATA_W +: DATA_W] & {DATA_W{grant_s[i]}});
      sel_cin_s = sel_cin_s | (req_cin[i] & grant_s[i]);
    end
  end

  // Next state: issue registers, tag shift, response capture and occupancy.
  always_comb begin
    din1_d = xfer_s ? sel_a_s   : din1_q;
    din2_d = xfer_s ? sel_b_s   : din2_q;
    cin_d  = xfer_s ? sel_cin_s : cin_q;

    tag_d[0].vld = xfer_s;
    tag_d[0].id  = grant_id_s;
    for (int k = 1; k <= PIPE_LAT; k++) begin
      tag_d[k] = tag_q[k-1];
    end

    rsp_valid_d = head_s.vld ? (ONE_HOT0 << head_s.id) : '0;
    rsp_sum_d   = head_s.vld ? add_dout : rsp_sum_q;
    rsp_cout_d  = head_s.vld ? add_cout : rsp_cout_q;

    // Count drops on the same edge the response becomes visible.
    case ({xfer_s, head_s.vld})
      2'b10:   inflight_d = inflight_q + CNT_ONE;
      2'b01:   inflight_d = inflight_q - CNT_ONE;
      default: inflight_d = inflight_q;
    endcase
  end

  // State registers; reset discards every in-flight tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din1_q      <= '0;
      din2_q      <= '0;
      cin_q       <= 1'b0;
      for (int k = 0; k <= PIPE_LAT; k++) begin
        tag_q[k] <= '0;
      end
      rsp_valid_q <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      inflight_q  <= '0;
    end else begin
      din1_q      <= din1_d;
      din2_q      <= din2_d;
      cin_q       <= cin_d;
      tag_q       <= tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      inflight_q  <= inflight_d;
    end
  end

  assign add_din_1 = din1_q;
  assign add_din_2 = din2_q;
  assign add_cin   = cin_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign inflight  = inflight_q;

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed bench for adder_share_arb with a two-stage behavioural adder
// attached to the add_* ports.
module tb_adder_share_arb;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int PL = 2;

  logic           clk       = 1'b0;
  logic           rst_n     = 1'b0;
  logic           arb_en    = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a     = '0;
  logic [N*W-1:0] req_b     = '0;
  logic [N-1:0]   req_cin   = '0;
  logic [W-1:0]   add_din_1;
  logic [W-1:0]   add_din_2;
  logic           add_cin;
  logic [W-1:0]   add_dout;
  logic           add_cout;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout;
  logic [1:0]     inflight;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [3:0] one4 = 4'b0001;
  logic [7:0] t_a    [4] = '{8'h12, 8'h80, 8'hF0, 8'h7F};
  logic [7:0] t_b    [4] = '{8'h34, 8'h80, 8'h20, 8'h01};
  logic       t_c    [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] t_sum  [4] = '{8'h46, 8'h01, 8'h10, 8'h81};
  logic       t_cout [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  adder_share_arb #(.N_REQ(N), .DATA_W(W), .PIPE_LAT(PL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .arb_en    (arb_en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .add_din_1 (add_din_1),
    .add_din_2 (add_din_2),
    .add_cin   (add_cin),
    .add_dout  (add_dout),
    .add_cout  (add_cout),
    .rsp_valid (rsp_valid),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .inflight  (inflight)
  );

  always #5 clk = ~clk;

  // Behavioural adder: result appears PL edges after the operands are registered.
  logic [W:0] s1_q;
  always @(posedge clk) begin
    s1_q                 <= {1'b0, add_din_1} + {1'b0, add_din_2} + {{W{1'b0}}, add_cin};
    {add_cout, add_dout} <= s1_q;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic c);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_cin[i]      = c;
  endtask

  task automatic load_table();
    for (int i = 0; i < N; i++) set_op(i, t_a[i], t_b[i], t_c[i]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    int ei;
    // Reset state
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_inflight",  32'(inflight),  32'h0);
    chk("rst_din1",      32'(add_din_1), 32'h0);
    chk("rst_sum",       32'(rsp_sum),   32'h0);
    do_reset();
    arb_en = 1'b1;
    #1;
    chk("idle_ready", 32'(req_ready), 32'h0);

    // Test 1: single op from requester 0, 5 + 10
    set_op(0, 8'd5, 8'd10, 1'b0);
    req_valid = 4'b0001;
    #1;
    chk("t1_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("t1_din1", 32'(add_din_1), 32'd5);
    chk("t1_din2", 32'(add_din_2), 32'd10);
    chk("t1_inflight", 32'(inflight), 32'd1);
    chk("t1_rsp_e0", 32'(rsp_valid), 32'h0);
    tick();
    chk("t1_rsp_e1", 32'(rsp_valid), 32'h0);
    tick();
    chk("t1_rsp_e2", 32'(rsp_valid), 32'h0);
    tick();
    chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t1_sum",       32'(rsp_sum),   32'd15);
    chk("t1_cout",      32'(rsp_cout),  32'd0);
    chk("t1_inflight0", 32'(inflight),  32'd0);
    tick();
    chk("t1_rsp_done", 32'(rsp_valid), 32'h0);

    // Test 2: all four valid, round-robin order 0,1,2,3,0,...
    do_reset();
    load_table();
    for (int t = 0; t < 11; t++) begin
      if (t < 8) begin
        req_valid = 4'b1111;
        #1;
        chk("t2_ready", 32'(req_ready), 32'(one4 << (t % 4)));
      end else begin
        req_valid = 4'b0000;
      end
      tick();
      if (t >= 3) begin
        ei = (t - 3) % 4;
        chk("t2_rsp_valid", 32'(rsp_valid), 32'(one4 << ei));
        chk("t2_sum",       32'(rsp_sum),   32'(t_sum[ei]));
        chk("t2_cout",      32'(rsp_cout),  32'(t_cout[ei]));
      end else begin
        chk("t2_rsp_idle",  32'(rsp_valid), 32'h0);
      end
      chk("t2_inflight", 32'(inflight),
          32'(((t + 1 < 8) ? t + 1 : 8) - ((t >= 3) ? t - 2 : 0)));
    end

    // Test 3: requester 1, FF + 01 + 1 wraps with carry
    set_op(1, 8'hFF, 8'h01, 1'b1);
    req_valid = 4'b0010;
    #1;
    chk("t3_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    tick();
    chk("t3_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("t3_sum",       32'(rsp_sum),   32'h01);
    chk("t3_cout",      32'(rsp_cout),  32'h1);
    tick();
    chk("t3_rsp_done",  32'(rsp_valid), 32'h0);
    chk("t3_sum_hold",  32'(rsp_sum),   32'h01);
    chk("t3_cout_hold", 32'(rsp_cout),  32'h1);

    // Test 4: requester 2 streams 50 ops, a=i, b=i+10
    for (int t = 0; t < 53; t++) begin
      if (t < 50) begin
        set_op(2, 8'(t), 8'(t + 10), 1'b0);
        req_valid = 4'b0100;
        #1;
        chk("t4_ready", 32'(req_ready), 32'h4);
      end else begin
        req_valid = 4'b0000;
      end
      tick();
      if (t >= 3) begin
        chk("t4_rsp_valid", 32'(rsp_valid), 32'h4);
        chk("t4_sum",       32'(rsp_sum),   32'(2 * (t - 3) + 10));
        chk("t4_cout",      32'(rsp_cout),  32'h0);
      end else begin
        chk("t4_rsp_idle",  32'(rsp_valid), 32'h0);
      end
    end

    // Test 5: arb_en drops with three ops in flight and requests pending
    load_table();
    req_valid = 4'b1111;
    #1;
    chk("t5_ready0", 32'(req_ready), 32'h8);
    tick();
    chk("t5_inflight0", 32'(inflight), 32'd1);
    chk("t5_ready1", 32'(req_ready), 32'h1);
    tick();
    chk("t5_ready2", 32'(req_ready), 32'h2);
    tick();
    chk("t5_inflight_max", 32'(inflight), 32'd3);
    arb_en = 1'b0;
    #1;
    chk("t5_ready_off", 32'(req_ready), 32'h0);
    tick();
    chk("t5_rsp3",  32'(rsp_valid), 32'h8);
    chk("t5_sum3",  32'(rsp_sum),   32'(t_sum[3]));
    chk("t5_inf2",  32'(inflight),  32'd2);
    tick();
    chk("t5_rsp0",  32'(rsp_valid), 32'h1);
    chk("t5_sum0",  32'(rsp_sum),   32'(t_sum[0]));
    chk("t5_inf1",  32'(inflight),  32'd1);
    tick();
    chk("t5_rsp1",  32'(rsp_valid), 32'h2);
    chk("t5_cout1", 32'(rsp_cout),  32'(t_cout[1]));
    chk("t5_inf0",  32'(inflight),  32'd0);
    tick();
    chk("t5_rsp_done",   32'(rsp_valid), 32'h0);
    chk("t5_inf_stay0",  32'(inflight),  32'd0);
    chk("t5_ready_still", 32'(req_ready), 32'h0);

    // Test 6: reset with three in flight discards them
    arb_en = 1'b1;
    #1;
    chk("t6_ready0", 32'(req_ready), 32'h4);
    tick();
    chk("t6_ready1", 32'(req_ready), 32'h8);
    tick();
    chk("t6_ready2", 32'(req_ready), 32'h1);
    tick();
    chk("t6_inflight3", 32'(inflight), 32'd3);
    req_valid = 4'b0000;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_inflight", 32'(inflight),  32'd0);
    chk("t6_rst_rsp",      32'(rsp_valid), 32'h0);
    chk("t6_rst_din1",     32'(add_din_1), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int t = 0; t < 5; t++) begin
      tick();
      chk("t6_no_stale_rsp", 32'(rsp_valid), 32'h0);
      chk("t6_inflight_0",   32'(inflight),  32'd0);
    end
    req_valid = 4'b1111;
    #1;
    chk("t6_first_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("t6_inflight_1", 32'(inflight), 32'd1);
    for (int t = 0; t < 3; t++) tick();
    chk("t6_rsp_req0", 32'(rsp_valid), 32'h1);
    chk("t6_sum_req0", 32'(rsp_sum),   32'(t_sum[0]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
